// File: rtl/replay_link_rx.sv
// Purpose: receive end of the ACK/NAK replay link. Each word is checked for parity
//          and sequence, good in-order words are forwarded, and ack/nak pulses go back.
// Latency: 1 cycle from an rx beat to out_valid_o and to its ack_o/nak_o pulse.
// Backpressure: none toward the link. A good beat that finds the output slot full is
//          dropped and nak'd, so the transmitter replays it later.
// Ports:   clk, rst_n (sync, active-low); rx_valid_i/rx_data_i/rx_seq_i/rx_par_i link input;
//          ack_o/nak_o/ack_seq_o return pulses; out_valid_o/out_data_o/out_ready_i downstream;
//          err_cnt_o saturating count of rejected words.
module replay_link_rx #(
    parameter int DATA_WIDTH   = 32,
    parameter int SEQ_WIDTH    = 4,
    parameter int ACK_INTERVAL = 1,
    parameter int NAK_TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic [SEQ_WIDTH-1:0]  rx_seq_i,
    input  logic                  rx_par_i,
    output logic                  ack_o,
    output logic                  nak_o,
    output logic [SEQ_WIDTH-1:0]  ack_seq_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic [15:0]           err_cnt_o
);

    localparam int TW = $clog2(NAK_TIMEOUT + 1);
    localparam int PW = SEQ_WIDTH + 1;

    typedef enum logic {
        RUN         = 1'b0,
        WAIT_REPLAY = 1'b1
    } state_t;

    state_t                state_q;
    logic [SEQ_WIDTH-1:0]  exp_seq_q;
    logic [SEQ_WIDTH-1:0]  exp_seq_d;
    logic [PW-1:0]         pend_q;
    logic [PW-1:0]         pend_d;
    logic [TW-1:0]         tmo_q;
    logic [15:0]           err_cnt_q;
    logic [15:0]           err_cnt_d;
    logic                  ack_q;
    logic                  nak_q;
    logic [SEQ_WIDTH-1:0]  ack_seq_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic par_ok;
    logic room;
    logic good;
    logic accept;
    logic ack_hit;
    logic tmo_hit;

    always_comb begin
        // Even parity: the XOR of parity bit, sequence and payload must be zero.
        par_ok    = ~(^{rx_par_i, rx_seq_i, rx_data_i});
        // The slot is free if empty or being drained in this same cycle.
        room      = ~out_valid_q | out_ready_i;
        good      = rx_valid_i & par_ok & (rx_seq_i == exp_seq_q);
        accept    = good & room;
        exp_seq_d = exp_seq_q + 1'b1;
        pend_d    = pend_q + 1'b1;
        ack_hit   = (pend_d == PW'(ACK_INTERVAL));
        tmo_hit   = (tmo_q == TW'(NAK_TIMEOUT - 1));
        err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            exp_seq_q   <= '0;
            pend_q      <= '0;
            tmo_q       <= '0;
            err_cnt_q   <= '0;
            ack_q       <= 1'b0;
            nak_q       <= 1'b0;
            ack_seq_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            // ack/nak are single-cycle pulses.
            ack_q <= 1'b0;
            nak_q <= 1'b0;

            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= rx_data_i;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end

            if (accept) begin
                // Identical acceptance in both states; WAIT_REPLAY resumes RUN.
                state_q   <= RUN;
                exp_seq_q <= exp_seq_d;
                ack_seq_q <= rx_seq_i;
                tmo_q     <= '0;
                if (ack_hit) begin
                    ack_q  <= 1'b1;
                    pend_q <= '0;
                end else begin
                    pend_q <= pend_d;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        if (rx_valid_i) begin
                            // First bad beat: request replay, forget un-acked words.
                            nak_q     <= 1'b1;
                            err_cnt_q <= err_cnt_d;
                            pend_q    <= '0;
                            tmo_q     <= '0;
                            state_q   <= WAIT_REPLAY;
                        end
                    end
                    WAIT_REPLAY: begin
                        // Stale/bad beats are discarded silently; only the
                        // timeout can re-issue the replay request.
                        if (tmo_hit) begin
                            nak_q <= 1'b1;
                            tmo_q <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign ack_o       = ack_q;
    assign nak_o       = nak_q;
    assign ack_seq_o   = ack_seq_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_replay_link_rx.sv
// Purpose: scoreboard bench for replay_link_rx; instance a uses ACK_INTERVAL=1,
//          instance b uses ACK_INTERVAL=4 and is scored only while chk_b is set.
// Inputs change 1 time unit after posedge; the monitor samples on negedge.
module tb_replay_link_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic [3:0]  rx_seq;
    logic        rx_par;
    logic        out_ready;

    logic        a_ack, a_nak, a_out_valid;
    logic [3:0]  a_ack_seq;
    logic [31:0] a_out_data;
    logic [15:0] a_err;
    logic        b_ack, b_nak, b_out_valid;
    logic [3:0]  b_ack_seq;
    logic [31:0] b_out_data;
    logic [15:0] b_err;

    always #5 clk = ~clk;

    replay_link_rx #(.DATA_WIDTH(32), .SEQ_WIDTH(4), .ACK_INTERVAL(1), .NAK_TIMEOUT(64)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_seq_i(rx_seq), .rx_par_i(rx_par),
        .ack_o(a_ack), .nak_o(a_nak), .ack_seq_o(a_ack_seq),
        .out_valid_o(a_out_valid), .out_data_o(a_out_data), .out_ready_i(out_ready),
        .err_cnt_o(a_err)
    );

    replay_link_rx #(.DATA_WIDTH(32), .SEQ_WIDTH(4), .ACK_INTERVAL(4), .NAK_TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_seq_i(rx_seq), .rx_par_i(rx_par),
        .ack_o(b_ack), .nak_o(b_nak), .ack_seq_o(b_ack_seq),
        .out_valid_o(b_out_valid), .out_data_o(b_out_data), .out_ready_i(out_ready),
        .err_cnt_o(b_err)
    );

    typedef struct { logic [31:0] d; int c; } dat_t;
    typedef struct { logic [3:0] s; int c; } ack_t;

    dat_t dat_q[$];
    ack_t acka_q[$];
    ack_t ackb_q[$];
    int   nak_q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: event seen with nothing expected (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents something.
    always @(negedge clk) begin
        dat_t e;
        ack_t k;
        int   n;
        if (a_out_valid === 1'b1 && out_ready === 1'b1) begin
            if (dat_q.size() == 0) fail_evt("out_extra");
            else begin
                e = dat_q.pop_front();
                chk("out_data", a_out_data, e.d);
                if (e.c >= 0) chk("out_cycle", cyc, e.c);
            end
        end
        if (a_ack === 1'b1) begin
            if (acka_q.size() == 0) fail_evt("ack_a_extra");
            else begin
                k = acka_q.pop_front();
                chk("ack_a_seq", a_ack_seq, k.s);
                chk("ack_a_cycle", cyc, k.c);
            end
        end
        if (a_nak === 1'b1) begin
            if (nak_q.size() == 0) fail_evt("nak_extra");
            else begin
                n = nak_q.pop_front();
                chk("nak_cycle", cyc, n);
            end
        end
        if (a_ack === 1'b1 && a_nak === 1'b1) fail_evt("ack_and_nak");
        if (chk_b) begin
            if (b_ack === 1'b1) begin
                if (ackb_q.size() == 0) fail_evt("ack_b_extra");
                else begin
                    k = ackb_q.pop_front();
                    chk("ack_b_seq", b_ack_seq, k.s);
                    chk("ack_b_cycle", cyc, k.c);
                end
            end
            if (b_nak === 1'b1) fail_evt("nak_b_extra");
        end
    end

    // dmode: 1 = check output cycle, 0 = data only, -1 = word never leaves (reset).
    task automatic beat(input logic [3:0] s, input logic [31:0] d, input bit flip,
                        input bit rdy, input bit acc, input bit nak, input int dmode);
        @(posedge clk); #1;
        rx_valid  = 1'b1;
        rx_seq    = s;
        rx_data   = d;
        rx_par    = ^{s, d};
        if (flip) rx_data[0] = ~d[0];
        out_ready = rdy;
        if (acc) begin
            if (dmode >= 0) dat_q.push_back('{d, (dmode != 0) ? cyc + 1 : -1});
            acka_q.push_back('{s, cyc + 1});
        end
        if (nak) nak_q.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ack_a",  a_ack, 0);       chk("rst_nak_a",  a_nak, 0);
        chk("rst_aseq_a", a_ack_seq, 0);   chk("rst_vld_a",  a_out_valid, 0);
        chk("rst_dat_a",  a_out_data, 0);  chk("rst_err_a",  a_err, 0);
        chk("rst_ack_b",  b_ack, 0);       chk("rst_nak_b",  b_nak, 0);
        chk("rst_vld_b",  b_out_valid, 0); chk("rst_err_b",  b_err, 0);
    endtask

    task automatic drain(input string nm);
        chk({nm, "_dat_left"},  dat_q.size(), 0);
        chk({nm, "_acka_left"}, acka_q.size(), 0);
        chk({nm, "_ackb_left"}, ackb_q.size(), 0);
        chk({nm, "_nak_left"},  nak_q.size(), 0);
    endtask

    initial begin
        int c0;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        rx_seq    = '0;
        rx_par    = 1'b0;
        out_ready = 1'b1;
        do_reset();

        // Clean stream with wrap 0..15,0.
        for (int i = 0; i < 17; i++)
            beat(4'(i % 16), 32'hA000_0000 + i, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        idle(3);
        chk("t1_err", a_err, 0);
        drain("t1");

        // Parity error on seq 2, stale 3,4 dropped silently, then replay.
        do_reset();
        beat(4'd0, 32'hB000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        beat(4'd1, 32'hB000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        beat(4'd2, 32'hB000_0002, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        beat(4'd3, 32'hB000_0003, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        beat(4'd4, 32'hB000_0004, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        beat(4'd2, 32'hB000_0002, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        beat(4'd3, 32'hB000_0003, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        beat(4'd4, 32'hB000_0004, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        idle(3);
        chk("t2_err", a_err, 1);
        drain("t2");

        // Backpressure: word 4 held, seq 5 finds no room, replayed later.
        do_reset();
        for (int i = 0; i < 4; i++)
            beat(4'(i), 32'hC000_0000 + i, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        beat(4'd4, 32'hC000_0004, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        beat(4'd5, 32'hC000_0005, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        repeat (4) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            @(negedge clk);
            chk("t3_hold_vld", a_out_valid, 1);
            chk("t3_hold_dat", a_out_data, 32'hC000_0004);
        end
        beat(4'd5, 32'hC000_0005, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        idle(3);
        chk("t3_err", a_err, 1);
        drain("t3");

        // Coalescing on instance b: acks after seq 3 and 7, pending 2 held.
        do_reset();
        chk_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            beat(4'(i), 32'hD000_0000 + i, 1'b0, 1'b1, 1'b1, 1'b0, 1);
            if (i == 3 || i == 7) ackb_q.push_back('{4'(i), cyc + 1});
        end
        idle(10);
        drain("t4");
        chk_b = 1'b0;

        // Timeout: seq 3 mismatches (expected 10), then 130 idle cycles.
        beat(4'd3, 32'hE000_0003, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        c0 = cyc;
        nak_q.push_back(c0 + 65);
        nak_q.push_back(c0 + 129);
        idle(130);
        chk("t5_err", a_err, 1);
        drain("t5");

        // Reset mid-stream with a held word and b pending=2.
        do_reset();
        chk_b = 1'b1;
        beat(4'd0, 32'hF000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        beat(4'd1, 32'hF000_0001, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t6_pre_vld", a_out_valid, 1);
        chk("t6_pre_dat", a_out_data, 32'hF000_0001);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            beat(4'(i), 32'hF000_0010 + i, 1'b0, 1'b1, 1'b1, 1'b0, 1);
            if (i == 3) ackb_q.push_back('{4'd3, cyc + 1});
        end
        idle(4);
        drain("t6");
        chk_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/replay_link_rx.md
Name: replay_link_rx

Overview:
- Receive end of the ACK/NAK replay link; the transmit end is the replay FIFO.
- Checks each incoming word for parity and sequence number.
- Forwards good in-order words to a downstream valid/ready consumer.
- Returns ack/nak pulses so the transmitter either commits or rewinds its read pointer and replays.

Parameters:
- DATA_WIDTH, 32: payload width.
- SEQ_WIDTH, 4: sequence-number width; sequence numbers wrap modulo 2^SEQ_WIDTH.
- ACK_INTERVAL, 1: number of accepted words per coalesced ack pulse (1..2^SEQ_WIDTH-1).
- NAK_TIMEOUT, 64: cycles spent in WAIT_REPLAY without the expected word before nak is re-issued.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- rx_valid_i  in  1  incoming word valid; no backpressure toward the link.
- rx_data_i  in  DATA_WIDTH  payload.
- rx_seq_i  in  SEQ_WIDTH  sequence number of the word.
- rx_par_i  in  1  even parity over {rx_seq_i, rx_data_i}.
- ack_o  out  1  one-cycle pulse; commit to the transmitter.
- nak_o  out  1  one-cycle pulse; replay request to the transmitter.
- ack_seq_o  out  SEQ_WIDTH  sequence number of the last accepted word; valid when ack_o=1.
- out_valid_o  out  1  downstream data valid.
- out_data_o  out  DATA_WIDTH  downstream payload.
- out_ready_i  in  1  downstream ready.
- err_cnt_o  out  16  saturating count of rejected words.

Behaviour:
- Reset values:
  - ack_o=0, nak_o=0, ack_seq_o=0, out_valid_o=0, out_data_o=0, err_cnt_o=0.
  - Expected sequence exp_seq=0; pending-ack counter=0; timeout counter=0; state=RUN.
  - Reset mid-operation discards the output register and any pending ack.
- Output stage is a single register. out_valid_o holds until out_valid_o & out_ready_i; then it clears in the same cycle unless a new word is loaded.
- A beat is "good" only if all three hold: rx_valid_i, parity correct (^{rx_par_i,rx_seq_i,rx_data_i}==0), and rx_seq_i==exp_seq.
- A beat is "room" if !out_valid_o | out_ready_i (the output slot is free this cycle).
- State RUN:
  - Good beat and room:
    - Load the output register; out_valid_o=1 next cycle.
    - exp_seq+1 with wrap; pending+1; ack_seq_o<=rx_seq_i.
    - If pending+1==ACK_INTERVAL: ack_o=1 next cycle, pending<=0.
  - Valid beat that is bad (parity error, sequence mismatch, or no room):
    - Word dropped; nak_o=1 next cycle; err_cnt_o+1 (saturating at 16'hFFFF).
    - Pending cleared without ack; state to WAIT_REPLAY; timeout counter<=0.
- State WAIT_REPLAY:
  - Every valid beat other than a good beat with room is silently discarded: no nak, no err_cnt increment.
  - Good beat with room: accept exactly as in RUN and return to RUN.
  - Timeout counter increments each cycle; on reaching NAK_TIMEOUT-1, nak_o=1 next cycle and the counter resets.
- ack_o and nak_o are never both 1 in the same cycle. Both are registered: one cycle latency from the triggering rx beat.
- Latency rx_valid_i to out_valid_o is 1 cycle.
- A duplicate of an already-accepted word (rx_seq_i==exp_seq-1, caused by over-replay) counts as a sequence mismatch and follows the rules above.
- Idle cycles (rx_valid_i=0) in RUN change nothing. A pending count below ACK_INTERVAL is held.

Test Plan:
- Clean stream, ACK_INTERVAL=1:
  - Stimulus: seq 0..15 then 0 (wrap), data 32'hA000_0000+i, out_ready_i=1 throughout.
  - Required: 17 words out in order, each 1 cycle after its rx beat; 17 ack pulses with ack_seq_o matching each word; nak never asserted.
- Parity error:
  - Stimulus: seq 0,1 good, seq 2 with a flipped data bit, then seq 3,4, then replay 2,3,4.
  - Required: nak_o pulses once, 1 cycle after the bad beat; 3,4 discarded; err_cnt_o=1; after the replay, output is 0,1,2,3,4 exactly once each.
- Backpressure:
  - Stimulus: out_ready_i=0 with a word held, then seq 5 arrives.
  - Required: seq 5 dropped with nak_o; the held word is stable until ready; replay of 5 with ready=1 is accepted.
- Coalescing, ACK_INTERVAL=4:
  - Stimulus: 10 good words.
  - Required: ack_o pulses after words 3 and 7 with ack_seq_o=3 and 7; pending=2 held, no third ack.
- Timeout:
  - Stimulus: a nak is triggered, then no valid beats for 130 cycles.
  - Required: nak_o re-pulses at 64 and 128 cycles after entering WAIT_REPLAY; err_cnt_o stays 1.
- Reset mid-stream:
  - Stimulus: rst_n=0 for 1 cycle while out_valid_o=1 with pending=2.
  - Required: all outputs 0 next cycle; the next accepted word must carry seq 0.
